// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller time-sharing one half_adder, LSB-first.
// Optional SERIAL_ADD_SUB_EN adds a SUB port (A - B via inverted B and carry-in of 1).

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             SUB,
`endif
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             CO
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, HA1, HA2, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             s1_q, s1_d;
   logic             c1_q, c1_d;
   logic             co_q, co_d;
   logic             sub_q;
   logic             sub_in;
   logic             ha_x, ha_y, ha_s, ha_c;

`ifdef SERIAL_ADD_SUB_EN
   logic sub_d;
   assign sub_in = SUB;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sub_q <= 1'b0;
      else        sub_q <= sub_d;
   end

   always_comb begin
      sub_d = sub_q;
      if ((state_q == IDLE || state_q == FIN) && START) sub_d = SUB;
   end
`else
   assign sub_in = 1'b0;
   assign sub_q  = 1'b0;
`endif

   // The only adder cell: HA1 adds the operand bits, HA2 folds in the running carry.
   half_adder u_ha (
      .x (ha_x),
      .y (ha_y),
      .s (ha_s),
      .c (ha_c)
   );

   always_comb begin
      if (state_q == HA2) begin
         ha_x = s1_q;
         ha_y = carry_q;
      end else begin
         ha_x = a_q[idx_q];
         ha_y = b_q[idx_q] ^ sub_q;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      s_d     = s_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      s1_d    = s1_q;
      c1_d    = c1_q;
      co_d    = co_q;
      case (state_q)
         IDLE, FIN: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               idx_d   = '0;
               carry_d = sub_in;
               state_d = HA1;
            end else begin
               state_d = IDLE;
            end
         end
         HA1: begin
            s1_d    = ha_s;
            c1_d    = ha_c;
            state_d = HA2;
         end
         HA2: begin
            // Sum bits shift in from the top so bit 0 lands at the LSB after WIDTH passes.
            acc_d   = {ha_s, acc_q[WIDTH-1:1]};
            carry_d = c1_q | ha_c;
            if (idx_q == LAST_IDX) begin
               s_d     = {ha_s, acc_q[WIDTH-1:1]};
               co_d    = c1_q | ha_c;
               state_d = FIN;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = HA1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         s1_q    <= 1'b0;
         c1_q    <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         s1_q    <= s1_d;
         c1_q    <= c1_d;
         co_q    <= co_d;
      end
   end

   assign BUSY = (state_q == HA1) || (state_q == HA2);
   assign DONE = (state_q == FIN);
   assign S    = s_q;
   assign CO   = co_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed-vector bench for serial_add_ctrl (WIDTH=8).
// SUB vectors run only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       START = 1'b0;
   logic [7:0] A = 8'h00;
   logic [7:0] B = 8'h00;
   logic       sub_in = 1'b0;
   logic       BUSY, DONE, CO;
   logic [7:0] S;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
`ifdef SERIAL_ADD_SUB_EN
      .SUB   (sub_in),
`endif
      .BUSY  (BUSY),
      .DONE  (DONE),
      .S     (S),
      .CO    (CO)
   );

   // Pulses START for one cycle, then waits (bounded) for DONE; lat counts cycles after the accepting edge.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        output int lat, output int busy_cnt);
      @(negedge CLK);
      A = a; B = b; sub_in = sub; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      A = ~a; B = ~b;
      lat = 1;
      busy_cnt = 0;
      while (!DONE && lat < 40) begin
         if (BUSY) busy_cnt++;
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b1; A = 8'hAA; B = 8'h55;
      repeat (3) @(negedge CLK);
      vectors++;
      if ({BUSY, DONE, S, CO} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b done=%b s=%h co=%b, want all 0", BUSY, DONE, S, CO);
      end
      START = 1'b0;
      RST_N = 1'b1;
      @(negedge CLK);
      vectors++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", BUSY, DONE);
      end
   endtask

   task automatic test_add_basic();
      int lat, bc;
      do_op(8'h35, 8'h1A, 1'b0, lat, bc);
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d, want 17", lat);
      end
      vectors++;
      if (bc !== 16) begin
         miscompares++;
         $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
      end
      vectors++;
      if (S !== 8'h4F || CO !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: got s=%h co=%b, want s=4f co=0", S, CO);
      end
      @(negedge CLK);
      vectors++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", DONE, BUSY);
      end
   endtask

   task automatic test_overflow();
      int lat, bc;
      do_op(8'hFF, 8'h01, 1'b0, lat, bc);
      vectors++;
      if (S !== 8'h00 || CO !== 1'b1 || lat !== 17) begin
         miscompares++;
         $display("FAIL ovf_ff_01: got s=%h co=%b lat=%0d, want s=00 co=1 lat=17", S, CO, lat);
      end
      // Result must hold through the start of the next op.
      @(negedge CLK);
      A = 8'hFF; B = 8'hFF; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (5) @(negedge CLK);
      vectors++;
      if (S !== 8'h00 || CO !== 1'b1 || BUSY !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_during_op: got s=%h co=%b busy=%b, want s=00 co=1 busy=1", S, CO, BUSY);
      end
      lat = 6;
      while (!DONE && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      vectors++;
      if (S !== 8'hFE || CO !== 1'b1 || lat !== 17) begin
         miscompares++;
         $display("FAIL ovf_ff_ff: got s=%h co=%b lat=%0d, want s=fe co=1 lat=17", S, CO, lat);
      end
      do_op(8'h80, 8'h7F, 1'b0, lat, bc);
      vectors++;
      if (S !== 8'hFF || CO !== 1'b0) begin
         miscompares++;
         $display("FAIL add_80_7f: got s=%h co=%b, want s=ff co=0", S, CO);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge CLK);
      A = 8'h12; B = 8'h34; START = 1'b1;
      @(negedge CLK);
      lat = 1;
      while (!DONE && lat < 40) begin
         A = 8'($urandom); B = 8'($urandom);
         @(negedge CLK);
         lat++;
      end
      vectors++;
      if (S !== 8'h46 || CO !== 1'b0 || lat !== 17) begin
         miscompares++;
         $display("FAIL b2b_first: got s=%h co=%b lat=%0d, want s=46 co=0 lat=17", S, CO, lat);
      end
      // START still high in FIN: these operands start the next op with no IDLE gap.
      A = 8'h80; B = 8'h80;
      @(negedge CLK);
      START = 1'b0;
      lat = 1;
      vectors++;
      if (BUSY !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_no_gap: got busy=%b, want 1", BUSY);
      end
      while (!DONE && lat < 40) begin
         A = 8'($urandom); B = 8'($urandom);
         @(negedge CLK);
         lat++;
      end
      vectors++;
      if (S !== 8'h00 || CO !== 1'b1 || lat !== 17) begin
         miscompares++;
         $display("FAIL b2b_second: got s=%h co=%b lat=%0d, want s=00 co=1 lat=17", S, CO, lat);
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      int seen_done;
      @(negedge CLK);
      A = 8'h35; B = 8'h1A; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      vectors++;
      if ({BUSY, DONE, S, CO} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_mid_async: got busy=%b done=%b s=%h co=%b, want all 0", BUSY, DONE, S, CO);
      end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      seen_done = 0;
      repeat (25) begin
         @(negedge CLK);
         if (DONE) seen_done++;
      end
      vectors++;
      if (seen_done !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", seen_done);
      end
      do_op(8'h01, 8'h02, 1'b0, lat, bc);
      vectors++;
      if (S !== 8'h03 || CO !== 1'b0 || lat !== 17) begin
         miscompares++;
         $display("FAIL reset_mid_next_op: got s=%h co=%b lat=%0d, want s=03 co=0 lat=17", S, CO, lat);
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      int lat, bc;
      do_op(8'h10, 8'h01, 1'b1, lat, bc);
      vectors++;
      if (S !== 8'h0F || CO !== 1'b1) begin
         miscompares++;
         $display("FAIL sub_10_01: got s=%h co=%b, want s=0f co=1", S, CO);
      end
      do_op(8'h00, 8'h01, 1'b1, lat, bc);
      vectors++;
      if (S !== 8'hFF || CO !== 1'b0) begin
         miscompares++;
         $display("FAIL sub_00_01: got s=%h co=%b, want s=ff co=0", S, CO);
      end
      do_op(8'h35, 8'h1A, 1'b0, lat, bc);
      vectors++;
      if (S !== 8'h4F || CO !== 1'b0) begin
         miscompares++;
         $display("FAIL sub0_add: got s=%h co=%b, want s=4f co=0", S, CO);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add_basic();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
